// File: rtl/cmp_arb_pkg.sv
// rtl/cmp_arb_pkg.sv - shared types, result bit positions and round-robin picker for cmp_arbiter
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int GT_BIT  = 2;
  localparam int EQ_BIT  = 1;
  localparam int LT_BIT  = 0;

  // Widest requester set the picker handles; narrower arbiters zero-extend.
  localparam int MAX_REQ = 16;

  // One-hot grant of the first valid bit at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [3:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] grant;
    logic [3:0]         idx;
    logic               found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = 4'((int'(ptr) + i) % n);
      if (i < n && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/comparator_8bit.sv
// rtl/comparator_8bit.sv - shared 8-bit magnitude comparator, signed when CMP_ARB_SIGNED_EN is defined
module comparator_8bit
  import cmp_arb_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [2:0] result
);

  // Exactly one of gt/eq/lt is set for any operand pair.
  always_comb begin
    result = '0;
`ifdef CMP_ARB_SIGNED_EN
    if ($signed(a) > $signed(b)) begin
      result[GT_BIT] = 1'b1;
    end else if (a == b) begin
      result[EQ_BIT] = 1'b1;
    end else begin
      result[LT_BIT] = 1'b1;
    end
`else
    if (a > b) begin
      result[GT_BIT] = 1'b1;
    end else if (a == b) begin
      result[EQ_BIT] = 1'b1;
    end else begin
      result[LT_BIT] = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter sharing one comparator_8bit; CMP_ARB_SIGNED_EN selects signed compare
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2:0]          rsp_out
);

  if (DW != 8) begin : g_bad_dw
    $error("cmp_arbiter: DW must be 8 to match the shared comparator");
  end

  state_t           state;
  state_t           next_state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_next;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   grant_idx;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    b_q;
  logic [N_REQ-1:0] grant;
  logic [2:0]       cmp_result;

  // Grant is computed every cycle but only exposed as req_ready while IDLE.
  assign grant    = N_REQ'(rr_pick(MAX_REQ'(req_valid), 4'(ptr), N_REQ));
  assign ptr_next = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;

  // Encode the one-hot grant into the winner's index for operand muxing.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDW'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: grant -> CMP, always CMP -> RESP, RESP waits for the consumer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|grant) next_state = CMP;
      CMP:     next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: accept only while idle, so rsp_ready never reaches req_ready.
  always_comb begin
    req_ready = '0;
    if (state == IDLE) begin
      req_ready = grant;
    end
  end

  // Datapath: latch winner, register compare result, advance pointer on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_out   <= 3'b000;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            a_q  <= req_a[int'(grant_idx)*DW +: DW];
            b_q  <= req_b[int'(grant_idx)*DW +: DW];
            id_q <= grant_idx;
          end
        end
        CMP: begin
          rsp_out   <= cmp_result;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  comparator_8bit u_cmp (
    .a      (a_q),
    .b      (b_q),
    .result (cmp_result)
  );

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench for cmp_arbiter against a transaction-level round-robin model
module tb_cmp_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [2:0]     rsp_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_grant;

  logic [N-1:0] pend;
  logic [7:0]   ma [N];
  logic [7:0]   mb [N];
  int           mptr;

  cmp_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8] = ma[i];
      req_b[i*8 +: 8] = mb[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int j, input logic [7:0] a, input logic [7:0] b);
    pend[j] = 1'b1;
    ma[j]   = a;
    mb[j]   = b;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_cmp(input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
`ifdef CMP_ARB_SIGNED_EN
    x = (a > 8'd127) ? int'(a) - 256 : int'(a);
    y = (b > 8'd127) ? int'(b) - 256 : int'(b);
`else
    x = int'(a);
    y = int'(b);
`endif
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // One arbitration round from an IDLE cycle; churn adds/withdraws requests while busy.
  task automatic do_txn(input int stall, input bit churn);
    int         w;
    logic [2:0] er;
    rsp_ready = (stall == 0);
    apply();
    w = model_pick();
    @(negedge clk);
    if (w < 0) begin
      check("idle_ready", req_ready, 0);
      check("idle_valid", rsp_valid, 0);
      step();
      return;
    end
    check("grant", req_ready, 1 << w);
    last_grant = cyc;
    er = model_cmp(ma[w], mb[w]);
    step();
    pend[w] = 1'b0;
    if (churn) begin
      for (int j = 0; j < N; j++) begin
        if (pend[j]) begin
          if ($urandom_range(0, 7) == 0) pend[j] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          new_req(j, 8'($urandom), 8'($urandom));
        end
      end
    end
    apply();
    @(negedge clk);
    check("cmp_ready", req_ready, 0);
    check("cmp_valid", rsp_valid, 0);
    step();
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_id", rsp_id, w);
      check("stall_out", rsp_out, er);
      check("stall_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, w);
    check("rsp_out", rsp_out, er);
    check("resp_ready", req_ready, 0);
    step();
    mptr = (w + 1) % N;
  endtask

  initial begin
    int g[4];
    int w;
    rst       = 1'b1;
    rsp_ready = 1'b0;
    pend      = '0;
    mptr      = 0;
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    apply();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_out", rsp_out, 0);
    check("rst_id", rsp_id, 0);
    check("rst_ready", req_ready, 0);
    step();
    rst = 1'b0;

    // All four at once: served 0,1,2,3, three cycles apart.
    new_req(0, 8'd5, 8'd20);
    new_req(1, 8'd15, 8'd15);
    new_req(2, 8'd255, 8'd0);
    new_req(3, 8'd0, 8'd255);
    for (int k = 0; k < 4; k++) begin
      do_txn(0, 1'b0);
      g[k] = last_grant;
      if (k > 0) check("spacing", g[k] - g[k-1], 3);
    end

    // Single request on requester 2; leaves ptr at 3.
    new_req(2, 8'd25, 8'd10);
    do_txn(0, 1'b0);
    check("single_rsp_gt", rsp_out, model_cmp(8'd25, 8'd10));

    // Fairness and wrap: ptr=3 with 1 and 3 pending -> 3 then 1.
    new_req(1, 8'd7, 8'd9);
    new_req(3, 8'd9, 8'd7);
    do_txn(0, 1'b0);
    check("wrap_ptr", mptr, 0);
    do_txn(0, 1'b0);

    // Back-pressure for 5 cycles with another request waiting.
    new_req(0, 8'd100, 8'd200);
    new_req(3, 8'd1, 8'd1);
    do_txn(5, 1'b0);
    do_txn(0, 1'b0);

    // Reset while in CMP discards the pair and clears the pointer.
    new_req(2, 8'd3, 8'd4);
    do_txn(0, 1'b0);
    new_req(1, 8'd77, 8'd66);
    apply();
    w = model_pick();
    @(negedge clk);
    check("pre_rst_grant", req_ready, 1 << w);
    step();
    pend = '0;
    apply();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_out", rsp_out, 0);
    check("mid_rst_id", rsp_id, 0);
    check("mid_rst_ready", req_ready, 0);
    step();
    rst  = 1'b0;
    mptr = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_valid", rsp_valid, 0);
      step();
    end
    for (int j = 0; j < N; j++) new_req(j, 8'(j * 40), 8'(200 - j * 30));
    do_txn(0, 1'b0);

    // Randomized traffic with stalls, late arrivals and withdrawals.
    for (int it = 0; it < 150; it++) begin
      for (int j = 0; j < N; j++) begin
        if (!pend[j] && $urandom_range(0, 2) == 0) new_req(j, 8'($urandom), 8'($urandom));
      end
      do_txn(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
